// File: rtl/fir_out_buf_pkg.sv
// Shared widths, sample type and pointer sizing for the FIR output buffer.
// Optional drop counter is enabled in the top level by FIR_OUT_BUF_CNT_EN.
package fir_out_buf_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int DEF_DEPTH  = 8;
    localparam int DROP_CNT_W = 8;
    // Decimation counter width covers the largest supported factor (255).
    localparam int DCNT_W     = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_out_buf_mem.sv
// Storage array for the output FIFO: one write port, asynchronous read.
// Latency: written data readable the cycle after the write edge.
// Backpressure: none; the caller gates wr_vld.
module fir_out_buf_mem
    import fir_out_buf_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [AW-1:0]    wr_ptr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_ptr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_vld) begin
            mem_d[wr_ptr] = wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr];

endmodule

// File: rtl/fir_out_buf.sv
// Decimating FWFT output buffer behind the FIR filter; FIR_OUT_BUF_CNT_EN adds DROP_CNT.
// Latency: a kept sample is on DOUT with VOUT=1 one cycle after its input edge.
// Backpressure: none upstream; kept samples arriving while full are dropped and flagged on OVF.
module fir_out_buf
    import fir_out_buf_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DECIM = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
    input  logic [WIDTH-1:0]           DIN,
    input  logic                       VIN,
    output logic [WIDTH-1:0]           DOUT,
    output logic                       VOUT,
    input  logic                       READY,
    output logic [$clog2(DEPTH):0]     LEVEL,
`ifdef FIR_OUT_BUF_CNT_EN
    output logic [DROP_CNT_W-1:0]      DROP_CNT,
`endif
    output logic                       OVF
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DECIM - 1);
    localparam logic [LW-1:0]     LEVEL_FULL = LW'(DEPTH);

    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;

    logic              empty;
    logic              full;
    logic              kept;
    logic              pop;
    logic              push;
    logic              drop;

    // CLR masks every datapath action so a flush cycle never writes or reads.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LEVEL_FULL);
        kept  = VIN && (dcnt_q == '0);
        pop   = !CLR && !empty && READY;
        push  = !CLR && kept && (!full || pop);
        drop  = !CLR && kept && full && !pop;
    end

    always_comb begin
        dcnt_d   = dcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (CLR) begin
            dcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            // The counter advances on every valid sample, dropped or not.
            if (VIN) begin
                dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + DCNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            dcnt_q   <= dcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    fir_out_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (push),
        .wr_ptr (wr_ptr_q),
        .wr_dat (DIN),
        .rd_ptr (rd_ptr_q),
        .rd_dat (DOUT)
    );

    assign VOUT  = !empty;
    assign LEVEL = level_q;
    assign OVF   = ovf_q;

`ifdef FIR_OUT_BUF_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (CLR) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_buf.sv
// Bench for fir_out_buf: two instances (DECIM=1 and DECIM=3) share stimulus; a queue model
// predicts accepted samples, occupancy and loss flags, and a negedge monitor checks them.
module tb_fir_out_buf;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int DEC0  = 1;
    localparam int DEC1  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         vin;
    logic         rdy;
    logic [W-1:0] din;

    logic [W-1:0] dout_w [2];
    logic         vout_w [2];
    logic         ovf_w  [2];
    logic [3:0]   lvl_w  [2];
`ifdef FIR_OUT_BUF_CNT_EN
    logic [7:0]   dcnt_w [2];
`endif

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

    int mlvl [2];
    int cnt  [2];
    int mdrop[2];
    bit movf [2];
    int chk_lvl [2];
    int chk_drop[2];
    bit chk_ovf [2];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    fir_out_buf #(.WIDTH(W), .DEPTH(DEPTH), .DECIM(DEC0)) u_d1 (
        .CLK(clk), .RST(rst), .CLR(clr), .DIN(din), .VIN(vin),
        .DOUT(dout_w[0]), .VOUT(vout_w[0]), .READY(rdy), .LEVEL(lvl_w[0]),
`ifdef FIR_OUT_BUF_CNT_EN
        .DROP_CNT(dcnt_w[0]),
`endif
        .OVF(ovf_w[0])
    );

    fir_out_buf #(.WIDTH(W), .DEPTH(DEPTH), .DECIM(DEC1)) u_d3 (
        .CLK(clk), .RST(rst), .CLR(clr), .DIN(din), .VIN(vin),
        .DOUT(dout_w[1]), .VOUT(vout_w[1]), .READY(rdy), .LEVEL(lvl_w[1]),
`ifdef FIR_OUT_BUF_CNT_EN
        .DROP_CNT(dcnt_w[1]),
`endif
        .OVF(ovf_w[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d got=%0h expected=%0h t=%0t", nm, i, act, req, $time);
        end
    endtask

    function automatic void qpush(input int i, input logic [W-1:0] d);
        if (i == 0) q0.push_back(d);
        else        q1.push_back(d);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W-1:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            mlvl[i] = 0; cnt[i] = 0; mdrop[i] = 0; movf[i] = 1'b0;
            chk_lvl[i] = 0; chk_drop[i] = 0; chk_ovf[i] = 1'b0;
        end
    endfunction

    // One clock of stimulus; the model predicts what the following rising edge does.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit c);
        @(negedge clk);
        vin = v; din = d; rdy = r; clr = c;
        for (int i = 0; i < 2; i++) begin
            int  dec;
            bit  pop_m, kept_m, push_m;
            dec = (i == 0) ? DEC0 : DEC1;
            chk_lvl[i]  = mlvl[i];
            chk_ovf[i]  = movf[i];
            chk_drop[i] = mdrop[i];
            if (c) begin
                if (i == 0) q0.delete(); else q1.delete();
                mlvl[i] = 0; cnt[i] = 0; movf[i] = 1'b0; mdrop[i] = 0;
            end else begin
                pop_m  = (mlvl[i] > 0) && r;
                kept_m = v && ((cnt[i] % dec) == 0);
                if (v) cnt[i]++;
                push_m = kept_m && ((mlvl[i] < DEPTH) || pop_m);
                if (push_m) qpush(i, d);
                if (kept_m && !push_m) begin
                    movf[i] = 1'b1;
                    if (mdrop[i] < 255) mdrop[i]++;
                end
                mlvl[i] = mlvl[i] + int'(push_m) - int'(pop_m);
            end
        end
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_level"}, i, lvl_w[i], 0);
            chk({nm, "_vout"},  i, vout_w[i], 0);
            chk({nm, "_ovf"},   i, ovf_w[i], 0);
            chk({nm, "_dout"},  i, dout_w[i], 0);
`ifdef FIR_OUT_BUF_CNT_EN
            chk({nm, "_dropcnt"}, i, dcnt_w[i], 0);
`endif
        end
    endtask

    // Reset asserted and released between clock edges, checked before any edge.
    task automatic rst_pulse();
        step(1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_zero("async_rst");
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("level", i, lvl_w[i], chk_lvl[i]);
                chk("vout",  i, vout_w[i], (chk_lvl[i] != 0));
                chk("ovf",   i, ovf_w[i], chk_ovf[i]);
`ifdef FIR_OUT_BUF_CNT_EN
                chk("drop_cnt", i, dcnt_w[i], chk_drop[i]);
`endif
                if (vout_w[i] && rdy && !clr) begin
                    if (qsize(i) == 0) begin
                        chk("pop_without_sample", i, 1, 0);
                    end else begin
                        chk("dout", i, dout_w[i], qpop(i));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; vin = 1'b0; rdy = 1'b0; din = '0;
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        // Isolated pulses, consumer always ready.
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, W'(k), 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Back-to-back samples 10..18: DECIM=3 instance keeps 10, 13, 16.
        for (int k = 10; k <= 18; k++) step(1'b1, W'(k), 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Overflow: 10 samples with consumer stalled.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k <= 9; k++) step(1'b1, W'(k), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("full_level", 0, lvl_w[0], 8);
        chk("full_ovf",   0, ovf_w[0], 1);
        chk("decim_level", 1, lvl_w[1], 4);
`ifdef FIR_OUT_BUF_CNT_EN
        chk("full_dropcnt", 0, dcnt_w[0], 2);
`endif

        // Full with simultaneous pop and kept sample: no drop, level holds.
        step(1'b1, 16'd100, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("full_pushpop_level", 0, lvl_w[0], 8);
`ifdef FIR_OUT_BUF_CNT_EN
        chk("full_pushpop_dropcnt", 0, dcnt_w[0], 2);
`endif
        repeat (10) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with five entries pending and a sample arriving in the same cycle.
        for (int k = 20; k < 25; k++) step(1'b1, W'(k), 1'b0, 1'b0);
        step(1'b1, 16'd55, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        for (int i = 0; i < 2; i++) chk("clr_level", i, lvl_w[i], 0);
        step(1'b1, 16'd77, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Same scenario through an asynchronous reset pulse.
        for (int k = 30; k < 40; k++) step(1'b1, W'(k), 1'b0, 1'b0);
        rst_pulse();
        step(1'b1, 16'd88, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic: stall-heavy then drain-heavy, with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            bit v, r, c;
            v = ($urandom_range(0, 3) != 0);
            r = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            step(v, W'($urandom), r, c);
        end

        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
        #2;
        for (int i = 0; i < 2; i++) chk("drain_empty", i, qsize(i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/fir_out_buf.md
# fir_out_buf

Output buffer stage sitting directly downstream of the FIR filter `myfir`. Takes the filter's `DOUT`/`VOUT` sample stream, which has no backpressure, and keeps every DECIM-th valid sample in a small first-word-fall-through FIFO. It presents the samples to the consumer (data sink or next stage) over a valid/ready handshake, and flags samples lost to overflow.

## Interface
- WIDTH, 16, sample width; matches filter output.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DECIM, 1, decimation factor; 1..255; 1 keeps every sample.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CLR  in  1  synchronous flush.
- DIN  in  WIDTH  sample from filter `DOUT`.
- VIN  in  1  sample valid from filter `VOUT`.
- DOUT  out  WIDTH  head-of-FIFO sample.
- VOUT  out  1  head valid (FIFO not empty).
- READY  in  1  consumer accepts head this cycle.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- OVF  out  1  sticky: at least one kept sample was dropped.

## Operation
- Decimation counter `dcnt` runs 0..DECIM-1 and advances only on `VIN`=1.
  - A sample is "kept" when `VIN`=1 and `dcnt`=0, so the first valid sample after reset or CLR is kept.
  - `dcnt` wraps from DECIM-1 to 0.
- Push = kept and (not full, or pop this cycle).
- Pop = `VOUT`=1 and `READY`=1.
- Drop = kept, full and no pop. The sample is discarded, `OVF` is set, and `dcnt` still advances.
- Full with simultaneous push and pop: both happen, `LEVEL` stays DEPTH, no drop.
- Empty with `READY`=1: no pop. No bypass path exists; the new sample only appears after it is written.
- Pointers wrap modulo DEPTH. Full is `LEVEL`=DEPTH; empty is `LEVEL`=0.
- `DOUT` is the memory entry at the read pointer. While `VOUT`=0 it is don't-care, and the bench must not check it then.
- CLR has priority over push and pop. It empties the FIFO, zeroes `dcnt` and clears `OVF`. Any `VIN` in the same cycle is ignored.
- Arithmetic: samples pass unmodified; no width change.

## Timing
- Reset values: `VOUT`=0, `LEVEL`=0, `OVF`=0, `DOUT`=0, pointers=0, `dcnt`=0, memory cleared.
- Latency: a sample kept at edge k has `VOUT`=1 and appears on `DOUT` in the cycle after edge k, when the FIFO was empty.
- Pop at edge k: the next entry is on `DOUT` in the cycle after edge k; `VOUT` drops if `LEVEL` reaches 0.
- `LEVEL` and `OVF` are registered, updated at the same edge as the push, pop or drop that changes them.
- Throughput: one push and one pop per cycle.
- `RST` asserted mid-stream returns every register to its reset value immediately, with no clock needed. The first edge after deassertion is a normal cycle.

## Configuration
- `FIR_OUT_BUF_CNT_EN` defined: adds output `DROP_CNT` (out, 8 bits).
  - Increments on every drop and saturates at 255.
  - Cleared by `RST` and `CLR`.
- `FIR_OUT_BUF_CNT_EN` undefined: the port and its counter are absent; only `OVF` reports loss.

## Structure
- Package `fir_out_buf_pkg` holds:
  - `SAMPLE_W`=16, `DEF_DEPTH`=8, `DROP_CNT_W`=8;
  - typedef `sample_t` (logic [SAMPLE_W-1:0]);
  - a pointer-width function.
- Sub-module `fir_out_buf_mem`: DEPTH x WIDTH register array with one write port, asynchronous read at the read pointer, and async clear on `RST`.
- Top level contains the decimation counter, pointers, level, flags and the optional drop counter.

## Test plan
- Reset then idle, DEPTH=8, DECIM=1 -> `VOUT`=0, `LEVEL`=0, `OVF`=0, `DOUT`=0.
- `VIN` pulses with DIN=1,2,3 and `READY`=1 throughout -> `DOUT` shows 1,2,3, each one cycle after its input; `LEVEL` never exceeds 1.
- DECIM=3, 9 consecutive valid samples 10..18, `READY`=1 -> output 10,13,16 only.
- `READY`=0, 10 samples 0..9 -> `LEVEL`=8, `OVF`=1, drain yields 0..7, `DROP_CNT`=2 when macro defined.
- Full FIFO, `READY`=1 and a kept sample in the same cycle -> `LEVEL` stays 8, no drop, `OVF` unchanged.
- `CLR` with `LEVEL`=5 and `VIN`=1 in the same cycle -> next cycle `LEVEL`=0, `VOUT`=0, `OVF`=0; the next valid sample is kept. Repeat with `RST` pulsed between clock edges -> same result with no clock edge needed.
